ysyx_24100012_sram: RTL and testbench

//  Clocked, handshaked successor to the DPI-backed combinational RAM: independent read and write

---
 rtl/ysyx_24100012_sram.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_24100012_sram.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_sram.sv
// Clocked valid/ready SRAM front end with independent read/write channels, access latency,
// byte strobes and range errors; a small word array stands in for the pmem backing store.
module ysyx_24100012_sram #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR   = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE      = 32'h0800_0000,
  parameter int unsigned           READ_LATENCY  = 1,
  parameter int unsigned           WRITE_LATENCY = 1,
  parameter int unsigned           PMEM_WORDS    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_resp_valid,
  input  logic                    rd_resp_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_err,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_resp_valid,
  input  logic                    wr_resp_ready,
  output logic                    wr_err
);

  localparam int unsigned NW   = DATA_WIDTH / 32;
  localparam int unsigned SB   = DATA_WIDTH / 8;
  localparam int unsigned IW   = $clog2(PMEM_WORDS);
  localparam int unsigned MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] RD_CNT0 = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_CNT0 = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] lo, hi, x;
    lo = {1'b0, ORIGIN_ADDR};
    hi = lo + {1'b0, MEM_SIZE};
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
    return a & ~ADDR_WIDTH'(SB - 1);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a, input int unsigned k);
    return IW'((a >> 2) + ADDR_WIDTH'(k));
  endfunction

  state_e                rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, wr_data_q, wr_data_d;
  logic [SB-1:0]         wr_strb_q, wr_strb_d;
  logic                  rd_err_q, rd_err_d, wr_err_q, wr_err_d;
  logic                  rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic                  rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic                  rd_accept, wr_accept, rd_fire, wr_fire, rd_ok, wr_ok;
  logic                  pmem_rd_en, pmem_wr_en;
  logic [IW-1:0]         rd_idx [NW];
  logic [IW-1:0]         wr_idx [NW];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [31:0]           mem [PMEM_WORDS];

  assign rd_accept  = (rd_state_q == S_IDLE) && rd_req_valid && rd_ready_q;
  assign wr_accept  = (wr_state_q == S_IDLE) && wr_req_valid && wr_ready_q;
  assign rd_fire    = (rd_state_q == S_WAIT) && (rd_cnt_q == '0);
  assign wr_fire    = (wr_state_q == S_WAIT) && (wr_cnt_q == '0);
  assign rd_ok      = in_range(rd_addr_q);
  assign wr_ok      = in_range(wr_addr_q);
  assign pmem_rd_en = rd_fire && rd_ok;
  assign pmem_wr_en = wr_fire && wr_ok && (|wr_strb_q);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (rd_state_q)
      S_IDLE: if (rd_accept) begin rd_state_d = S_WAIT; rd_cnt_d = RD_CNT0; end
      S_WAIT: if (rd_cnt_q == '0) rd_state_d = S_RESP; else rd_cnt_d = rd_cnt_q - CW'(1);
      S_RESP: if (rd_resp_ready) rd_state_d = S_IDLE;
      default: rd_state_d = S_IDLE;
    endcase
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    unique case (wr_state_q)
      S_IDLE: if (wr_accept) begin wr_state_d = S_WAIT; wr_cnt_d = WR_CNT0; end
      S_WAIT: if (wr_cnt_q == '0) wr_state_d = S_RESP; else wr_cnt_d = wr_cnt_q - CW'(1);
      S_RESP: if (wr_resp_ready) wr_state_d = S_IDLE;
      default: wr_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < NW; k++) begin
      rd_idx[k] = word_idx(rd_addr_q, k);
      wr_idx[k] = word_idx(wr_addr_q, k);
    end
  end

  // A write committing on the same edge is merged in, so reads observe it (write-before-read).
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      rd_word[32*k +: 32] = mem[rd_idx[k]];
      for (int unsigned j = 0; j < NW; j++)
        for (int unsigned b = 0; b < 4; b++)
          if (pmem_wr_en && (wr_idx[j] == rd_idx[k]) && wr_strb_q[4*j+b])
            rd_word[32*k+8*b +: 8] = wr_data_q[32*j+8*b +: 8];
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_err_d  = wr_err_q;
    if (rd_accept) rd_addr_d = align(rd_addr);
    if (rd_fire) begin
      rd_data_d = pmem_rd_en ? rd_word : '0;
      rd_err_d  = !rd_ok;
    end
    if (wr_accept) begin
      wr_addr_d = align(wr_addr);
      wr_data_d = wr_data;
      wr_strb_d = wr_strb;
    end
    if (wr_fire) wr_err_d = !wr_ok;
    rd_valid_d = (rd_state_d == S_RESP);
    wr_valid_d = (wr_state_d == S_RESP);
    rd_ready_d = (rd_state_d == S_IDLE);
    wr_ready_d = (wr_state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= S_IDLE;
      wr_state_q <= S_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_data_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_data_q  <= rd_data_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pmem_wr_en) begin
      for (int unsigned j = 0; j < NW; j++)
        for (int unsigned b = 0; b < 4; b++)
          if (wr_strb_q[4*j+b]) mem[wr_idx[j]][8*b +: 8] <= wr_data_q[32*j+8*b +: 8];
    end
  end

  assign rd_req_ready  = rd_ready_q;
  assign wr_req_ready  = wr_ready_q;
  assign rd_resp_valid = rd_valid_q;
  assign wr_resp_valid = wr_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_err        = rd_err_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_ysyx_24100012_sram.sv
// Directed bench for ysyx_24100012_sram: a latency-1 instance for the main scenarios and a
// READ_LATENCY=4 instance for latency/backpressure.
module tb_ysyx_24100012_sram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          rd_calls = 0;
  int          wr_calls = 0;

  logic        rd_req_valid = 1'b0, rd_req_ready, rd_resp_valid, rd_resp_ready = 1'b0, rd_err;
  logic [31:0] rd_addr = '0, rd_data;
  logic        wr_req_valid = 1'b0, wr_req_ready, wr_resp_valid, wr_resp_ready = 1'b0, wr_err;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;

  logic        d4_rd_req_valid = 1'b0, d4_rd_req_ready, d4_rd_resp_valid, d4_rd_resp_ready = 1'b0, d4_rd_err;
  logic [31:0] d4_rd_addr = '0, d4_rd_data;
  logic        d4_wr_req_valid = 1'b0, d4_wr_req_ready, d4_wr_resp_valid, d4_wr_resp_ready = 1'b0, d4_wr_err;
  logic [31:0] d4_wr_addr = '0, d4_wr_data = '0;
  logic [3:0]  d4_wr_strb = '0;

  always #5 clk = ~clk;

  ysyx_24100012_sram dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_data(rd_data), .rd_err(rd_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready), .wr_err(wr_err)
  );

  ysyx_24100012_sram #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(d4_rd_req_valid), .rd_req_ready(d4_rd_req_ready), .rd_addr(d4_rd_addr),
    .rd_resp_valid(d4_rd_resp_valid), .rd_resp_ready(d4_rd_resp_ready), .rd_data(d4_rd_data), .rd_err(d4_rd_err),
    .wr_req_valid(d4_wr_req_valid), .wr_req_ready(d4_wr_req_ready), .wr_addr(d4_wr_addr), .wr_data(d4_wr_data),
    .wr_strb(d4_wr_strb), .wr_resp_valid(d4_wr_resp_valid), .wr_resp_ready(d4_wr_resp_ready), .wr_err(d4_wr_err)
  );

  always @(posedge clk) begin
    if (dut.pmem_rd_en) rd_calls++;
    if (dut.pmem_wr_en) wr_calls++;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic e);
    int n;
    wr_addr = a; wr_data = d; wr_strb = s; wr_req_valid = 1'b1; wr_resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wr_req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin checks++; failures++; $display("FAIL wr_accept_timeout ready=%0b want 1", wr_req_ready); end
    @(posedge clk); #1 wr_req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (!wr_resp_valid && n < 20);
    if (n >= 20) begin checks++; failures++; $display("FAIL wr_resp_timeout valid=%0b want 1", wr_resp_valid); end
    e = wr_err;
    @(posedge clk); #1 wr_resp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
    int n;
    rd_addr = a; rd_req_valid = 1'b1; rd_resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rd_req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin checks++; failures++; $display("FAIL rd_accept_timeout ready=%0b want 1", rd_req_ready); end
    @(posedge clk); #1 rd_req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!rd_resp_valid && lat < 20);
    if (lat >= 20) begin checks++; failures++; $display("FAIL rd_resp_timeout valid=%0b want 1", rd_resp_valid); end
    d = rd_data; e = rd_err;
    @(posedge clk); #1 rd_resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_resp_valid !== 1'b0 || wr_resp_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valids rd=%0b wr=%0b want 0 0", rd_resp_valid, wr_resp_valid); end
    checks++; if (rd_data !== 32'h0 || rd_err !== 1'b0 || wr_err !== 1'b0) begin failures++;
      $display("FAIL reset_data rd_data=%h rd_err=%0b wr_err=%0b want 0", rd_data, rd_err, wr_err); end
    checks++; if (rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0 || d4_rd_req_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready_low rd=%0b wr=%0b d4=%0b want 0", rd_req_ready, wr_req_ready, d4_rd_req_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rd_req_ready !== 1'b0) begin failures++;
      $display("FAIL ready_before_edge got %0b want 0", rd_req_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1 || d4_wr_req_ready !== 1'b1) begin failures++;
      $display("FAIL ready_after_release rd=%0b wr=%0b d4=%0b want 1", rd_req_ready, wr_req_ready, d4_wr_req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rw;
    logic [31:0] d; logic e; int lat, rc;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_wr_err got %0b want 0", e); end
    rc = rd_calls;
    do_read(32'h8000_0000, d, e, lat);
    checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++;
      $display("FAIL basic_rd_data got %h err=%0b want deadbeef err=0", d, e); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL basic_rd_latency got %0d want 1", lat); end
    checks++; if (rd_calls !== rc + 1) begin failures++; $display("FAIL basic_rd_calls got %0d want %0d", rd_calls, rc + 1); end
  endtask

  task automatic test_strobe;
    logic [31:0] d; logic e; int lat;
    do_write(32'h8000_0000, 32'h1122_3344, 4'b0101, e);
    do_read(32'h8000_0002, d, e, lat);
    checks++; if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL strobe_merge got %h want de22be44", d); end
  endtask

  task automatic test_range;
    logic [31:0] d; logic e; int lat, rc, wc;
    rc = rd_calls; wc = wr_calls;
    do_read(32'h7FFF_FFFC, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++;
      $display("FAIL range_low got err=%0b data=%h want err=1 data=0", e, d); end
    do_read(32'h8800_0000, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++;
      $display("FAIL range_high got err=%0b data=%h want err=1 data=0", e, d); end
    do_read(32'h87FF_FFFC, d, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL range_last_word got err=%0b want 0", e); end
    do_write(32'h8800_0000, 32'h5555_5555, 4'b1111, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL range_wr_err got %0b want 1", e); end
    checks++; if (rd_calls !== rc + 1 || wr_calls !== wc) begin failures++;
      $display("FAIL range_calls rd=%0d wr=%0d want rd=%0d wr=%0d", rd_calls, wr_calls, rc + 1, wc); end
  endtask

  task automatic test_latency_backpressure;
    int n;
    d4_wr_addr = 32'h8000_0004; d4_wr_data = 32'h0BAD_C0DE; d4_wr_strb = 4'hF;
    d4_wr_resp_ready = 1'b1; d4_wr_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!d4_wr_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 d4_wr_req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (!d4_wr_resp_valid && n < 20);
    checks++; if (d4_wr_resp_valid !== 1'b1 || d4_wr_err !== 1'b0) begin failures++;
      $display("FAIL lat4_preload valid=%0b err=%0b want 1 0", d4_wr_resp_valid, d4_wr_err); end
    @(posedge clk); #1 d4_wr_resp_ready = 1'b0;
    d4_rd_addr = 32'h8000_0004; d4_rd_resp_ready = 1'b0; d4_rd_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!d4_rd_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 d4_rd_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (d4_rd_resp_valid !== (k == 4) || d4_rd_req_ready !== 1'b0) begin failures++;
        $display("FAIL lat4_valid_edge%0d valid=%0b ready=%0b want %0b 0", k, d4_rd_resp_valid, d4_rd_req_ready, k == 4); end
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (d4_rd_resp_valid !== 1'b1 || d4_rd_data !== 32'h0BAD_C0DE || d4_rd_err !== 1'b0 || d4_rd_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL lat4_hold%0d valid=%0b data=%h err=%0b ready=%0b want 1 0badc0de 0 0",
                 k, d4_rd_resp_valid, d4_rd_data, d4_rd_err, d4_rd_req_ready); end
    end
    d4_rd_resp_ready = 1'b1;
    @(posedge clk); #1 d4_rd_resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (d4_rd_resp_valid !== 1'b0 || d4_rd_req_ready !== 1'b1) begin failures++;
      $display("FAIL lat4_release valid=%0b ready=%0b want 0 1", d4_rd_resp_valid, d4_rd_req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_edge_and_reset;
    logic [31:0] d; logic e; int lat, rc, wc;
    do_write(32'h8000_0020, 32'hA5A5_A5A5, 4'hF, e);
    rd_addr = 32'h8000_0010; wr_addr = 32'h8000_0010; wr_data = 32'hCAFE_F00D; wr_strb = 4'hF;
    rd_resp_ready = 1'b1; wr_resp_ready = 1'b1; rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    @(negedge clk);
    checks++; if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin failures++;
      $display("FAIL same_edge_ready rd=%0b wr=%0b want 1 1", rd_req_ready, wr_req_ready); end
    @(posedge clk); #1 begin rd_req_valid = 1'b0; wr_req_valid = 1'b0; end
    @(posedge clk); @(negedge clk);
    checks++; if (rd_resp_valid !== 1'b1 || wr_resp_valid !== 1'b1 || rd_data !== 32'hCAFE_F00D) begin failures++;
      $display("FAIL same_edge_rw rd_v=%0b wr_v=%0b data=%h want 1 1 cafef00d", rd_resp_valid, wr_resp_valid, rd_data); end
    @(posedge clk); #1 begin rd_resp_ready = 1'b0; wr_resp_ready = 1'b0; end
    rc = rd_calls; wc = wr_calls;
    rd_addr = 32'h8000_0020; wr_addr = 32'h8000_0020; wr_data = 32'h1111_1111;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    @(posedge clk); #1 begin rd_req_valid = 1'b0; wr_req_valid = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_resp_valid !== 1'b0 || wr_resp_valid !== 1'b0 || rd_req_ready !== 1'b0 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_wait rd_v=%0b wr_v=%0b ready=%0b data=%h want 0 0 0 0", rd_resp_valid, wr_resp_valid, rd_req_ready, rd_data); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rd_calls !== rc || wr_calls !== wc) begin failures++;
      $display("FAIL reset_in_wait_calls rd=%0d wr=%0d want %0d %0d", rd_calls, wr_calls, rc, wc); end
    do_read(32'h8000_0020, d, e, lat);
    checks++; if (d !== 32'hA5A5_A5A5 || e !== 1'b0) begin failures++;
      $display("FAIL reset_mem_unchanged got %h err=%0b want a5a5a5a5 0", d, e); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_strobe();
    test_range();
    test_latency_backpressure();
    test_same_edge_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
